peak_extractor: RTL and testbench

PEAK_EXTRACTOR -- requirements
Module: peak_extractor

---
 rtl/peak_extractor.sv | 155 +++++++++++++++
 tb/tb_peak_extractor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/peak_extractor.sv
// Peak extractor: triggers on a trapezoid filter pulse, averages its flat top and
// presents amplitude, trigger timestamp and clip flag through a valid/ready result register.
module peak_extractor #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int THRESHOLD        = 100,
  parameter int HYST             = 10,
  parameter int RISE_TIME        = 4,
  parameter int FLAT_LOG2        = 2,
  parameter int TS_WIDTH         = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic                        peak_ready,
  output logic                        peak_valid,
  output logic [SIZE_FILTER_DATA-1:0] peak_amp,
  output logic [TS_WIDTH-1:0]         peak_time,
  output logic                        peak_clip,
  output logic [7:0]                  drop_count
);

  localparam int ACC_W  = SIZE_FILTER_DATA + FLAT_LOG2;
  localparam int FCNT_W = FLAT_LOG2 + 1;

  localparam logic [SIZE_FILTER_DATA-1:0] TRIG_LVL   = SIZE_FILTER_DATA'(THRESHOLD);
  localparam logic [SIZE_FILTER_DATA-1:0] REARM_LVL  = SIZE_FILTER_DATA'(THRESHOLD - HYST);
  localparam logic [SIZE_FILTER_DATA-1:0] FULL_SCALE = '1;
  localparam logic [7:0]                  RISE_LAST  = 8'(RISE_TIME - 1);
  localparam logic [FCNT_W-1:0]           FLAT_LAST  = FCNT_W'((1 << FLAT_LOG2) - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_FLAT = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  // A one-sample rise means the trigger sample already completes the rise.
  localparam logic [1:0] ST_AFTER_TRIG = (RISE_TIME == 1) ? ST_FLAT : ST_RISE;

  logic [1:0]          r_state;
  logic                r_arm;
  logic [TS_WIDTH-1:0] r_ts;
  logic [TS_WIDTH-1:0] r_pend_time;
  logic [7:0]          r_rise_cnt;
  logic [FCNT_W-1:0]   r_flat_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic                r_clip;

  logic                        w_low;
  logic                        w_high;
  logic                        w_trigger;
  logic                        w_flat_last;
  logic                        w_sample_clip;
  logic                        w_accept;
  logic [ACC_W-1:0]            w_sum;
  logic [SIZE_FILTER_DATA-1:0] w_avg;

  assign w_low         = (filter_data <= REARM_LVL);
  assign w_high        = (filter_data > TRIG_LVL);
  assign w_trigger     = (r_state == ST_IDLE) && r_arm && w_high;
  assign w_flat_last   = (r_state == ST_FLAT) && !w_low && (r_flat_cnt == FLAT_LAST);
  assign w_sample_clip = (filter_data == FULL_SCALE);
  assign w_accept      = !peak_valid || peak_ready;
  assign w_sum         = r_acc + ACC_W'(filter_data);
  assign w_avg         = w_sum[ACC_W-1:FLAT_LOG2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // Event sequencer; a low sample during rise or flat abandons the event without re-arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_arm       <= 1'b0;
      r_pend_time <= '0;
      r_rise_cnt  <= '0;
      r_flat_cnt  <= '0;
      r_acc       <= '0;
      r_clip      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_acc      <= '0;
          r_flat_cnt <= '0;
          r_clip     <= 1'b0;
          if (w_low) begin
            r_arm <= 1'b1;
          end else if (w_trigger) begin
            r_arm       <= 1'b0;
            r_pend_time <= r_ts;
            r_rise_cnt  <= 8'd1;
            r_state     <= ST_AFTER_TRIG;
          end
        end
        ST_RISE: begin
          if (w_low) begin
            r_state <= ST_IDLE;
          end else if (r_rise_cnt == RISE_LAST) begin
            r_state <= ST_FLAT;
          end else begin
            r_rise_cnt <= r_rise_cnt + 8'd1;
          end
        end
        ST_FLAT: begin
          if (w_low) begin
            r_state <= ST_IDLE;
          end else if (r_flat_cnt == FLAT_LAST) begin
            r_state    <= ST_FALL;
            r_acc      <= '0;
            r_flat_cnt <= '0;
            r_clip     <= 1'b0;
          end else begin
            r_acc      <= w_sum;
            r_flat_cnt <= r_flat_cnt + FCNT_W'(1);
            r_clip     <= r_clip | w_sample_clip;
          end
        end
        ST_FALL: begin
          if (w_low) begin
            r_state <= ST_IDLE;
            r_arm   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A held, unaccepted result wins over a new one; the newcomer is only counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_valid <= 1'b0;
      peak_amp   <= '0;
      peak_time  <= '0;
      peak_clip  <= 1'b0;
      drop_count <= '0;
    end else if (w_flat_last) begin
      if (w_accept) begin
        peak_valid <= 1'b1;
        peak_amp   <= w_avg;
        peak_time  <= r_pend_time;
        peak_clip  <= r_clip | w_sample_clip;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (peak_valid && peak_ready) begin
      peak_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peak_extractor.sv
// Directed bench for peak_extractor: a default instance plus a 4-bit timestamp instance,
// both fed the same samples, with expected results queued at stimulus time.
module tb_peak_extractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        peak_ready;
  logic [15:0] filter_data;

  logic        peak_valid;
  logic [15:0] peak_amp;
  logic [31:0] peak_time;
  logic        peak_clip;
  logic [7:0]  drop_count;

  logic        peak_valid4;
  logic [15:0] peak_amp4;
  logic [3:0]  peak_time4;
  logic        peak_clip4;
  logic [7:0]  drop_count4;

  typedef struct packed {
    logic [15:0] amp;
    logic [31:0] ts;
    logic        clip;
  } res_t;

  res_t expQ[$];
  res_t expQ4[$];
  int   checks   = 0;
  int   failures = 0;
  int   tbTime   = 0;

  peak_extractor dut (
    .clk        (clk),
    .reset      (reset),
    .filter_data(filter_data),
    .peak_ready (peak_ready),
    .peak_valid (peak_valid),
    .peak_amp   (peak_amp),
    .peak_time  (peak_time),
    .peak_clip  (peak_clip),
    .drop_count (drop_count)
  );

  peak_extractor #(.TS_WIDTH(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .filter_data(filter_data),
    .peak_ready (peak_ready),
    .peak_valid (peak_valid4),
    .peak_amp   (peak_amp4),
    .peak_time  (peak_time4),
    .peak_clip  (peak_clip4),
    .drop_count (drop_count4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: flat-top mean of four samples, truncated, clip if any sample is full scale.
  function automatic res_t model(input int trig, input logic [15:0] f0, input logic [15:0] f1,
                                 input logic [15:0] f2, input logic [15:0] f3);
    res_t r;
    logic [17:0] s;
    s      = 18'(f0) + 18'(f1) + 18'(f2) + 18'(f3);
    r.amp  = s[17:2];
    r.ts   = 32'(trig);
    r.clip = (f0 == 16'hFFFF) || (f1 == 16'hFFFF) || (f2 == 16'hFFFF) || (f3 == 16'hFFFF);
    return r;
  endfunction

  task automatic applyStimulus(input logic [15:0] d, input logic r);
    filter_data = d;
    peak_ready  = r;
    @(posedge clk);
    #1;
    tbTime++;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    tbTime = 0;
  endtask

  // mode: 0 no valid check, 1 one-cycle pulse at sample 7, 2 sticky from sample 7, 3 always high
  task automatic runPulse(input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] f2,
                          input logic [15:0] f3, input logic r, input int mode, input bit push,
                          input string tag);
    logic [15:0] seq [12];
    res_t e;
    res_t e4;
    bit   expV;
    seq = '{16'd250, 16'd500, 16'd750, 16'd1000, f0, f1, f2, f3,
            16'd750, 16'd500, 16'd250, 16'd0};
    e  = model(tbTime, f0, f1, f2, f3);
    e4 = e;
    e4.ts = e.ts & 32'hF;
    if (push) begin
      expQ.push_back(e);
      expQ4.push_back(e4);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(seq[i], r);
      if (mode != 0) begin
        expV = (mode == 1) ? (i == 7) : (mode == 2) ? (i >= 7) : 1'b1;
        checkOutput({tag, "_valid"}, {31'b0, peak_valid}, {31'b0, expV});
      end
    end
  endtask

  // Results are compared when the consumer accepts them.
  always @(negedge clk) begin : monitor
    res_t e;
    if (!reset && peak_valid && peak_ready) begin
      checkOutput("unexpected_result", {31'b0, expQ.size() != 0}, 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("peak_amp",  32'(peak_amp),  32'(e.amp));
        checkOutput("peak_time", peak_time,      e.ts);
        checkOutput("peak_clip", {31'b0, peak_clip}, {31'b0, e.clip});
      end
    end
    if (!reset && peak_valid4 && peak_ready) begin
      checkOutput("unexpected_result4", {31'b0, expQ4.size() != 0}, 32'd1);
      if (expQ4.size() != 0) begin
        e = expQ4.pop_front();
        checkOutput("peak_amp4",  32'(peak_amp4),  32'(e.amp));
        checkOutput("peak_time4", 32'(peak_time4), e.ts);
        checkOutput("peak_clip4", {31'b0, peak_clip4}, {31'b0, e.clip});
      end
    end
  end

  initial begin
    filter_data = '0;
    peak_ready  = 1'b0;
    reset       = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_valid", {31'b0, peak_valid}, 32'd0);
    checkOutput("reset_amp",   32'(peak_amp),       32'd0);
    checkOutput("reset_time",  peak_time,           32'd0);
    checkOutput("reset_clip",  {31'b0, peak_clip},  32'd0);
    checkOutput("reset_drop",  32'(drop_count),     32'd0);
    checkOutput("reset_valid4", {31'b0, peak_valid4}, 32'd0);
    doReset();

    $display("[TB] basic event");
    repeat (5) applyStimulus(16'd0, 1'b1);
    runPulse(16'd1000, 16'd1000, 16'd1000, 16'd1000, 1'b1, 1, 1'b1, "basic");

    $display("[TB] clip event");
    runPulse(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b1, "clip");

    $display("[TB] truncating average");
    runPulse(16'd1000, 16'd1001, 16'd1002, 16'd1002, 1'b1, 1, 1'b1, "trunc");

    $display("[TB] backpressure");
    runPulse(16'd2000, 16'd2000, 16'd2000, 16'd2000, 1'b0, 2, 1'b1, "bp1");
    runPulse(16'd3000, 16'd3000, 16'd3000, 16'd3000, 1'b0, 3, 1'b0, "bp2");
    checkOutput("bp_drop",  32'(drop_count),  32'd1);
    checkOutput("bp_drop4", 32'(drop_count4), 32'd1);
    applyStimulus(16'd0, 1'b1);
    checkOutput("bp_release_valid", {31'b0, peak_valid}, 32'd0);
    applyStimulus(16'd0, 1'b0);
    checkOutput("bp_idle_valid", {31'b0, peak_valid}, 32'd0);

    $display("[TB] noise reject");
    doReset();
    repeat (2) applyStimulus(16'd0, 1'b1);
    applyStimulus(16'd150, 1'b1);
    checkOutput("noise_valid_a", {31'b0, peak_valid}, 32'd0);
    applyStimulus(16'd60, 1'b1);
    checkOutput("noise_valid_b", {31'b0, peak_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'd0, 1'b1);
      checkOutput("noise_valid_c", {31'b0, peak_valid}, 32'd0);
    end
    checkOutput("noise_drop", 32'(drop_count), 32'd0);
    runPulse(16'd1200, 16'd1200, 16'd1200, 16'd1200, 1'b1, 1, 1'b1, "post_noise");

    $display("[TB] reset during flat top");
    repeat (2) applyStimulus(16'd0, 1'b1);
    applyStimulus(16'd250, 1'b1);
    applyStimulus(16'd500, 1'b1);
    applyStimulus(16'd750, 1'b1);
    applyStimulus(16'd1000, 1'b1);
    applyStimulus(16'd1000, 1'b1);
    applyStimulus(16'd1000, 1'b1);
    reset = 1'b1;
    #2;
    checkOutput("midrst_valid", {31'b0, peak_valid}, 32'd0);
    checkOutput("midrst_amp",   32'(peak_amp),       32'd0);
    checkOutput("midrst_time",  peak_time,           32'd0);
    checkOutput("midrst_clip",  {31'b0, peak_clip},  32'd0);
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(16'd1000, 1'b1);
      checkOutput("midrst_hold_valid", {31'b0, peak_valid}, 32'd0);
    end
    applyStimulus(16'd90, 1'b1);
    applyStimulus(16'd0, 1'b1);
    runPulse(16'd1500, 16'd1500, 16'd1500, 16'd1500, 1'b1, 1, 1'b1, "post_reset");

    $display("[TB] timestamp wrap");
    doReset();
    repeat (15) applyStimulus(16'd0, 1'b1);
    runPulse(16'd1000, 16'd1000, 16'd1000, 16'd1000, 1'b1, 1, 1'b1, "wrap1");
    repeat (7) applyStimulus(16'd0, 1'b1);
    runPulse(16'd800, 16'd800, 16'd800, 16'd800, 1'b1, 1, 1'b1, "wrap2");

    repeat (3) applyStimulus(16'd0, 1'b1);
    checkOutput("pending_results",  32'(expQ.size()),  32'd0);
    checkOutput("pending_results4", 32'(expQ4.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
